// File: rtl/lsu_ip_input_sampler.sv
// Input sampler for the LSU input-peripheral bank: synchronises, debounces and packs switches/keys.
// Optional `LSU_IP_SAMPLER_IRQ_EN adds irq_o, high while any sticky press flag is set.
module lsu_ip_input_sampler #(
    parameter int unsigned SW_W   = 18,
    parameter int unsigned KEY_W  = 4,
    parameter int unsigned DB_CNT = 500000,
    parameter int unsigned CNT_W  = $clog2(DB_CNT)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [SW_W-1:0]   sw_i,
    input  logic [KEY_W-1:0]  key_ni,
    input  logic              clr_valid_i,
    input  logic [KEY_W-1:0]  clr_mask_i,
    output logic [31:0]       pwdata_o,
    output logic              pwrite_o
`ifdef LSU_IP_SAMPLER_IRQ_EN
    ,
    output logic              irq_o
`endif
);

    localparam int unsigned IN_W = SW_W + KEY_W;
    // Idle levels: switches off, keys released (active-low, so 1)
    localparam logic [IN_W-1:0]  SYNC_RST = {{KEY_W{1'b1}}, {SW_W{1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DB_CNT - 1);

    logic [IN_W-1:0]  meta;
    logic [IN_W-1:0]  sync;
    logic [IN_W-1:0]  clean;
    logic [IN_W-1:0]  stable;
    logic [IN_W-1:0]  stable_nxt;
    logic [KEY_W-1:0] sticky;
    logic [KEY_W-1:0] sticky_nxt;
    logic [KEY_W-1:0] rise;
    logic [KEY_W-1:0] clr;
    logic [31:0]      word;

    // Two-flop synchroniser on the raw inputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta <= SYNC_RST;
            sync <= SYNC_RST;
        end else begin
            meta <= {key_ni, sw_i};
            sync <= meta;
        end
    end

    // XOR with the idle pattern flips key bits so 1 = pressed
    assign clean = sync ^ SYNC_RST;

    for (genvar g = 0; g < IN_W; g++) begin : g_db
        logic [CNT_W-1:0] cnt;
        logic             mismatch;

        assign mismatch      = (clean[g] != stable[g]);
        assign stable_nxt[g] = (mismatch && (cnt == CNT_MAX)) ? clean[g] : stable[g];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt <= '0;
            end else if (!mismatch || (cnt == CNT_MAX)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Set beats clear when a debounced press lands with a clear request
    always_comb begin
        rise       = stable_nxt[IN_W-1:SW_W] & ~stable[IN_W-1:SW_W];
        clr        = clr_valid_i ? clr_mask_i : '0;
        sticky_nxt = (sticky & ~clr) | rise;
        word       = 32'({sticky, stable});
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stable <= '0;
            sticky <= '0;
        end else begin
            stable <= stable_nxt;
            sticky <= sticky_nxt;
        end
    end

    // Publish only on change so every strobe carries a new word
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pwdata_o <= '0;
            pwrite_o <= 1'b0;
        end else if (word != pwdata_o) begin
            pwdata_o <= word;
            pwrite_o <= 1'b1;
        end else begin
            pwrite_o <= 1'b0;
        end
    end

`ifdef LSU_IP_SAMPLER_IRQ_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= |sticky_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_lsu_ip_input_sampler.sv
// Bench for lsu_ip_input_sampler: directed scenarios plus random stimulus against a
// window-based reference model (a bit flips after DB_CNT consecutive opposite synced samples).
module tb_lsu_ip_input_sampler;

    localparam int unsigned SW_W   = 18;
    localparam int unsigned KEY_W  = 4;
    localparam int unsigned DB_CNT = 4;
    localparam int unsigned IN_W   = SW_W + KEY_W;

    logic             clk;
    logic             rst_n;
    logic [SW_W-1:0]  sw;
    logic [KEY_W-1:0] key_n;
    logic             clr_valid;
    logic [KEY_W-1:0] clr_mask;
    logic [31:0]      pwdata;
    logic             pwrite;
`ifdef LSU_IP_SAMPLER_IRQ_EN
    logic             irq;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    lsu_ip_input_sampler #(
        .SW_W   (SW_W),
        .KEY_W  (KEY_W),
        .DB_CNT (DB_CNT)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .sw_i        (sw),
        .key_ni      (key_n),
        .clr_valid_i (clr_valid),
        .clr_mask_i  (clr_mask),
        .pwdata_o    (pwdata),
        .pwrite_o    (pwrite)
`ifdef LSU_IP_SAMPLER_IRQ_EN
        ,
        .irq_o       (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state; hist[k] holds the internal-polarity input sampled k edges ago
    logic [IN_W-1:0]  hist [DB_CNT+2];
    logic [IN_W-1:0]  m_stable = '0;
    logic [KEY_W-1:0] m_sticky = '0;
    logic [31:0]      exp_pwdata = '0;
    logic             exp_pwrite = 1'b0;
    logic             exp_irq = 1'b0;

    task automatic model_step();
        logic [IN_W-1:0]  nxt;
        logic [KEY_W-1:0] rise;
        logic [31:0]      cur;
        logic             flip;
        if (!rst_n) begin
            for (int k = 0; k < DB_CNT + 2; k++) hist[k] = '0;
            m_stable   = '0;
            m_sticky   = '0;
            exp_pwdata = '0;
            exp_pwrite = 1'b0;
            exp_irq    = 1'b0;
        end else begin
            cur        = 32'({m_sticky, m_stable});
            exp_pwrite = (cur != exp_pwdata);
            exp_pwdata = cur;
            for (int k = DB_CNT + 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = {~key_n, sw};
            for (int i = 0; i < IN_W; i++) begin
                flip = 1'b1;
                for (int j = 0; j < DB_CNT; j++)
                    if (hist[2+j][i] == m_stable[i]) flip = 1'b0;
                nxt[i] = flip ? ~m_stable[i] : m_stable[i];
            end
            rise     = nxt[IN_W-1:SW_W] & ~m_stable[IN_W-1:SW_W];
            m_sticky = (m_sticky & ~(clr_valid ? clr_mask : '0)) | rise;
            m_stable = nxt;
            exp_irq  = |m_sticky;
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        check("pwdata", pwdata, exp_pwdata);
        check("pwrite", 32'(pwrite), 32'(exp_pwrite));
`ifdef LSU_IP_SAMPLER_IRQ_EN
        check("irq", 32'(irq), 32'(exp_irq));
`endif
    end

    task automatic wait_edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        sw        = '0;
        key_n     = '1;
        clr_valid = 1'b0;
        clr_mask  = '0;

        // Reset held: inputs toggle, outputs stay 0
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sw = SW_W'($urandom);
            check("reset_pwdata", pwdata, 32'h0);
        end
        @(negedge clk);
        sw    = '0;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("idle_pwrite", 32'(pwrite), 32'h0);
        end

        // Switch settle: exactly DB_CNT+3 edges
        sw = SW_W'(5);
        wait_edges(6);
        check("settle_early", pwdata, 32'h0);
        wait_edges(1);
        check("settle_data", pwdata, 32'h0000_0005);
        check("settle_strobe", 32'(pwrite), 32'h1);
        wait_edges(1);
        check("settle_single", 32'(pwrite), 32'h0);

        // Glitch shorter than the window is rejected
        sw = SW_W'(5 | 8);
        wait_edges(3);
        sw = SW_W'(5);
        wait_edges(10);
        check("glitch_data", pwdata, 32'h0000_0005);

        // Key press sets level and sticky; release keeps sticky
        key_n = 4'b1110;
        wait_edges(6);
        check("key_early", pwdata, 32'h0000_0005);
        wait_edges(1);
        check("key_press", pwdata, 32'h0044_0005);
        key_n = 4'b1111;
        wait_edges(7);
        check("key_release", pwdata, 32'h0040_0005);

        // Sticky clear shows two cycles after the request
        clr_valid = 1'b1;
        clr_mask  = 4'b0001;
        wait_edges(1);
        clr_valid = 1'b0;
        check("clr_mid", pwdata, 32'h0040_0005);
        wait_edges(1);
        check("clr_done", pwdata, 32'h0000_0005);

        // Press coinciding with a clear: set wins
        key_n = 4'b1110;
        wait_edges(7);
        key_n = 4'b1111;
        wait_edges(7);
        check("resticky", pwdata, 32'h0040_0005);
        key_n = 4'b1110;
        wait_edges(5);
        clr_valid = 1'b1;
        clr_mask  = 4'b0001;
        wait_edges(1);
        clr_valid = 1'b0;
        wait_edges(1);
        check("set_wins", pwdata, 32'h0044_0005);
        key_n = 4'b1111;
        wait_edges(7);

        // Reset mid-debounce restarts the full latency from release
        sw = SW_W'(3);
        wait_edges(3);
        rst_n = 1'b0;
        wait_edges(2);
        check("midrst_data", pwdata, 32'h0);
        rst_n = 1'b1;
        wait_edges(6);
        check("midrst_early", pwdata, 32'h0);
        wait_edges(1);
        check("midrst_data2", pwdata, 32'h0000_0003);
        check("midrst_strobe", 32'(pwrite), 32'h1);

        // Randomised traffic, checked every cycle against the model
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) sw = SW_W'($urandom);
            else if ($urandom_range(0, 9) == 0) sw[$urandom_range(0, SW_W-1)] ^= 1'b1;
            if ($urandom_range(0, 5) == 0) key_n = KEY_W'($urandom);
            clr_valid = ($urandom_range(0, 5) == 0);
            clr_mask  = KEY_W'($urandom);
            rst_n     = ($urandom_range(0, 299) != 0);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        clr_valid = 1'b0;
        wait_edges(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_ip_input_sampler.md
Name: lsu_ip_input_sampler

Overview:
- Front end for the LSU input-peripheral bank: samples raw board switches and active-low push-buttons, synchronises and debounces them.
- Packs the cleaned inputs plus sticky key-press flags into one 32-bit word.
- Presents the word on pwdata_o with a one-cycle pwrite_o strobe whenever it changes; the input-peripheral bank captures that word for loads to read.
- Software clears sticky flags through a clear-mask pulse.

Parameters:
- SW_W, 18, number of switch inputs.
- KEY_W, 4, number of push-button inputs; SW_W + 2*KEY_W <= 32.
- DB_CNT, 500000, debounce stability window in clk_i cycles; minimum 2.
- CNT_W, $clog2(DB_CNT), width of each per-bit debounce counter.

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- sw_i  input  SW_W  raw asynchronous switch levels, 1 = on.
- key_ni  input  KEY_W  raw asynchronous buttons, 0 = pressed.
- clr_valid_i  input  1  one-cycle request to clear sticky flags.
- clr_mask_i  input  KEY_W  sticky bits to clear when clr_valid_i = 1.
- pwdata_o  output  32  packed input word toward the input-peripheral bank.
- pwrite_o  output  1  one-cycle strobe, pwdata_o holds a new value.

Behaviour:
- Reset: one clock, clk_i; rst_ni asynchronous, active-low.
  - Switch sync flops clear to 0; key sync flops set to 1 (released).
  - Debounced levels, counters and sticky flags clear to 0.
  - pwdata_o = 0, pwrite_o = 0.
  - Reset asserted mid-debounce discards the count in progress.
- Sync: two-flop synchroniser per input bit. Keys are inverted after sync, so internal 1 = pressed.
- Debounce, per bit, every cycle:
  - If synced value == stable value: counter <= 0.
  - Else if counter == DB_CNT-1: stable <= synced value, counter <= 0.
  - Else: counter <= counter+1.
  - A glitch shorter than DB_CNT cycles never changes the stable value. A mismatch that vanishes for one cycle restarts the count.
- Sticky press flags, per key:
  - Set on the cycle the debounced key goes 0->1.
  - Cleared when clr_valid_i = 1 and the matching clr_mask_i bit = 1.
  - Set and clear in the same cycle on the same bit: set wins.
  - clr_mask_i is ignored when clr_valid_i = 0.
- Packing:
  - [SW_W-1:0] = debounced switches.
  - [SW_W+KEY_W-1:SW_W] = debounced key levels.
  - [SW_W+2*KEY_W-1:SW_W+KEY_W] = sticky flags.
  - Remaining upper bits = 0.
- Output register: each cycle, if the packed word != pwdata_o, then pwdata_o <= packed word and pwrite_o <= 1; otherwise pwrite_o <= 0.
  - Consecutive changes give back-to-back strobes.
  - pwrite_o is never high with an unchanged pwdata_o.
- Latency: a raw edge held stable appears on pwdata_o, with pwrite_o = 1, DB_CNT+3 rising edges after it is first sampled.
  - 2 sync + DB_CNT debounce + 1 output register.
  - Sticky bit changes driven by a debounced edge show in the same pwdata_o update as the key level.
  - A clear shows on pwdata_o 2 cycles after clr_valid_i: flag register, then output register.
- No handshake back-pressure; the downstream bank must accept every strobe.

Optional Feature:
- Macro: LSU_IP_SAMPLER_IRQ_EN.
- Defined: adds output port irq_o (1 bit), registered, high while any sticky flag is set. It updates in the same cycle the sticky register changes, so it leads pwdata_o by one cycle. Reset value 0.
- Undefined: no irq_o port and no IRQ logic.

Test Plan:
- Reset check: DB_CNT=4, hold rst_ni=0, toggle sw_i -> pwdata_o = 0 and pwrite_o = 0 throughout. Release reset with all inputs idle -> no pwrite_o pulse.
- Switch settle: set sw_i = 18'h00005 and hold -> exactly 7 edges later pwdata_o = 32'h00000005 with a single pwrite_o pulse.
- Glitch reject: pulse sw_i[3] high for 3 cycles, then low -> pwdata_o unchanged and no pwrite_o.
- Key press: drive key_ni = 4'b1110 and hold -> pwdata_o = 32'h00440000 (level bit 18 and sticky bit 22). Release to 4'b1111 -> pwdata_o = 32'h00400000.
- Sticky clear vs set: with sticky[0] = 1, pulse clr_valid_i with clr_mask_i = 4'b0001 -> pwdata_o bit 22 clears 2 cycles later. Repeat with a new debounced press landing in the same cycle -> bit 22 stays 1.
- Reset mid-operation: assert rst_ni = 0 three cycles into a sw_i debounce, then release with the input still changed -> the full DB_CNT+3 latency restarts from the release.
